// File: rtl/mcpu_core_fetch_queue_pkg.sv
// Shared defaults for the fetch queue and the I$ request/response buses.
package mcpu_core_fetch_queue_pkg;
  localparam int FQ_PACKET_W  = 128;
  localparam int FQ_VPC_W     = 28;
  localparam int FQ_PPAGE_W   = 20;
  localparam int FQ_PGOFF_W   = 8;
  localparam int FQ_DEPTH     = 4;
  localparam int FQ_IC_ADDR_W = FQ_PPAGE_W + FQ_PGOFF_W;
  localparam int FQ_IC_DATA_W = FQ_PACKET_W;
endpackage

// File: rtl/mcpu_core_fetch_ring.sv
// In-order packet ring: entries allocated at issue, filled on I$ return, popped to decode.
module mcpu_core_fetch_ring
  import mcpu_core_fetch_queue_pkg::*;
#(
  parameter int PACKET_W = FQ_PACKET_W,
  parameter int VPC_W    = FQ_VPC_W,
  parameter int DEPTH    = FQ_DEPTH,
  parameter bit BYPASS   = 1'b0,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                gclk,
  input  logic                grst_n,
  input  logic                i_flush,
  input  logic                i_alloc,
  input  logic [VPC_W-1:0]    i_alloc_vpc,
  input  logic                i_fill,
  input  logic                i_fill_wr,
  input  logic [PACKET_W-1:0] i_fill_data,
  input  logic                i_pop,
  output logic                o_head_vld,
  output logic                o_byp,
  output logic [PACKET_W-1:0] o_head_pkt,
  output logic [VPC_W-1:0]    o_head_vpc,
  output logic [CNT_W-1:0]    o_alloc_cnt,
  output logic [CNT_W-1:0]    o_pend_cnt
);
  logic [DEPTH-1:0][PACKET_W-1:0] r_data;
  logic [DEPTH-1:0][VPC_W-1:0]    r_vpc;
  logic [DEPTH-1:0]               r_filled;
  logic [PTR_W-1:0]               r_head, r_tail, r_fill;
  logic [CNT_W-1:0]               r_cnt, r_pend;

  // Stale filled bits may linger in unallocated slots, so head validity also needs r_cnt.
  assign o_head_vld  = (r_cnt != '0) & r_filled[r_head];
  assign o_byp       = BYPASS & i_fill & (r_head == r_fill) & (r_pend != '0) & ~r_filled[r_head];
  assign o_head_pkt  = r_data[r_head];
  assign o_head_vpc  = r_vpc[r_head];
  assign o_alloc_cnt = r_cnt;
  assign o_pend_cnt  = r_pend;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_data   <= '0;
      r_vpc    <= '0;
      r_filled <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_fill   <= '0;
      r_cnt    <= '0;
      r_pend   <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_pend <= '0;
    end else begin
      if (i_alloc) begin
        r_vpc[r_tail]    <= i_alloc_vpc;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + PTR_W'(1);
      end
      if (i_fill) begin
        if (i_fill_wr) begin
          r_data[r_fill]   <= i_fill_data;
          r_filled[r_fill] <= 1'b1;
        end
        r_fill <= r_fill + PTR_W'(1);
      end
      if (i_pop) r_head <= r_head + PTR_W'(1);
      r_cnt  <= r_cnt + CNT_W'(i_alloc) - CNT_W'(i_pop);
      r_pend <= r_pend + CNT_W'(i_alloc) - CNT_W'(i_fill);
    end
  end
endmodule

// File: rtl/mcpu_core_fetch_queue.sv
// Fetch stage: credit-gated I$ issue, flush with stale-return drop counting.
// Optional same-cycle response-to-decode bypass: define MCPU_CORE_FETCH_BYPASS_EN.
module mcpu_core_fetch_queue
  import mcpu_core_fetch_queue_pkg::*;
#(
  parameter int PACKET_W = FQ_PACKET_W,
  parameter int VPC_W    = FQ_VPC_W,
  parameter int PPAGE_W  = FQ_PPAGE_W,
  parameter int PGOFF_W  = FQ_PGOFF_W,
  parameter int DEPTH    = FQ_DEPTH
) (
  input  logic                       clkrst_core_clk,
  input  logic                       clkrst_core_rst_n,
  input  logic                       ft2f_readyout,
  output logic                       ft2f_readyin,
  input  logic [PPAGE_W-1:0]         ft2f_in_physpage,
  input  logic [VPC_W-1:0]           ft2f_in_virtpc,
  output logic                       f2ic_req_valid,
  input  logic                       f2ic_req_ready,
  output logic [PPAGE_W+PGOFF_W-1:0] f2ic_req_addr,
  input  logic                       ic2f_rsp_valid,
  input  logic [PACKET_W-1:0]        ic2f_rsp_data,
  output logic                       f2d_readyout,
  input  logic                       f2d_readyin,
  output logic [PACKET_W-1:0]        f2d_out_packet,
  output logic [VPC_W-1:0]           f2d_out_virtpc,
  input  logic                       pipe_flush
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef MCPU_CORE_FETCH_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic [CNT_W-1:0]    r_drop_cnt, w_alloc_cnt, w_pend_cnt;
  logic                w_credit_ok, w_issue, w_rsp_live, w_byp, w_head_vld, w_rdy, w_pop;
  logic [PACKET_W-1:0] w_head_pkt;
  logic [VPC_W-1:0]    w_head_vpc;

  // Dropped-but-outstanding returns still occupy I$ slots, so they hold credit too.
  assign w_credit_ok = ({1'b0, w_alloc_cnt} + {1'b0, r_drop_cnt}) < (CNT_W+1)'(DEPTH);
  assign w_issue     = ft2f_readyout & f2ic_req_ready & w_credit_ok & ~pipe_flush;
  assign w_rsp_live  = ic2f_rsp_valid & (r_drop_cnt == '0) & ~pipe_flush;
  assign w_rdy       = (w_head_vld | w_byp) & ~pipe_flush;
  assign w_pop       = w_rdy & f2d_readyin;

  mcpu_core_fetch_ring #(
    .PACKET_W (PACKET_W),
    .VPC_W    (VPC_W),
    .DEPTH    (DEPTH),
    .BYPASS   (BYP_EN)
  ) u_ring (
    .gclk        (clkrst_core_clk),
    .grst_n      (clkrst_core_rst_n),
    .i_flush     (pipe_flush),
    .i_alloc     (w_issue),
    .i_alloc_vpc (ft2f_in_virtpc),
    .i_fill      (w_rsp_live),
    .i_fill_wr   (w_rsp_live & ~(w_byp & f2d_readyin)),
    .i_fill_data (ic2f_rsp_data),
    .i_pop       (w_pop),
    .o_head_vld  (w_head_vld),
    .o_byp       (w_byp),
    .o_head_pkt  (w_head_pkt),
    .o_head_vpc  (w_head_vpc),
    .o_alloc_cnt (w_alloc_cnt),
    .o_pend_cnt  (w_pend_cnt)
  );

  // Outputs are forced low while reset is asserted, even with live inputs.
  assign f2ic_req_valid = clkrst_core_rst_n & ft2f_readyout & w_credit_ok & ~pipe_flush;
  assign ft2f_readyin   = clkrst_core_rst_n & f2ic_req_ready & w_credit_ok & ~pipe_flush;
  assign f2ic_req_addr  = clkrst_core_rst_n ? {ft2f_in_physpage, ft2f_in_virtpc[PGOFF_W-1:0]} : '0;
  assign f2d_readyout   = clkrst_core_rst_n & w_rdy;
  assign f2d_out_packet = !clkrst_core_rst_n ? '0 : (w_byp ? ic2f_rsp_data : w_head_pkt);
  assign f2d_out_virtpc = clkrst_core_rst_n ? w_head_vpc : '0;

  // A response arriving in the flush cycle is itself stale, hence the -1.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n)                  r_drop_cnt <= '0;
    else if (pipe_flush)                     r_drop_cnt <= r_drop_cnt + w_pend_cnt - CNT_W'(ic2f_rsp_valid);
    else if (ic2f_rsp_valid && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
  end

  always @(posedge clkrst_core_clk)
    if (clkrst_core_rst_n && ic2f_rsp_valid)
      assert (r_drop_cnt != '0 || w_pend_cnt != '0);
endmodule

// File: tb/tb_mcpu_core_fetch_queue.sv
// Directed bench for mcpu_core_fetch_queue (DEPTH=4, I$ model with 2-cycle return).
module tb_mcpu_core_fetch_queue;
`ifdef MCPU_CORE_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic ft2f_readyout, ft2f_readyin, f2ic_req_valid, f2ic_req_ready;
  logic [19:0] ft2f_in_physpage;
  logic [27:0] ft2f_in_virtpc, f2d_out_virtpc;
  logic [27:0] f2ic_req_addr;
  logic ic2f_rsp_valid, f2d_readyout, f2d_readyin, pipe_flush;
  logic [127:0] ic2f_rsp_data, f2d_out_packet;

  always #5 clk = ~clk;

  mcpu_core_fetch_queue dut (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n),
    .ft2f_readyout(ft2f_readyout), .ft2f_readyin(ft2f_readyin),
    .ft2f_in_physpage(ft2f_in_physpage), .ft2f_in_virtpc(ft2f_in_virtpc),
    .f2ic_req_valid(f2ic_req_valid), .f2ic_req_ready(f2ic_req_ready), .f2ic_req_addr(f2ic_req_addr),
    .ic2f_rsp_valid(ic2f_rsp_valid), .ic2f_rsp_data(ic2f_rsp_data),
    .f2d_readyout(f2d_readyout), .f2d_readyin(f2d_readyin),
    .f2d_out_packet(f2d_out_packet), .f2d_out_virtpc(f2d_out_virtpc), .pipe_flush(pipe_flush)
  );

  int errors = 0, checks = 0;
  int cyc_n = 0, n_pop = 0, n_iss = 0, first_pop_t = 0, last_pop_t = 0;
  bit rsp_en;
  logic [27:0] pc;
  logic [27:0] exp_q[$];
  logic [27:0] icq_pc[$];
  int          icq_t[$];
  logic obs_reqv, obs_readyin, obs_rdy, obs_issue, obs_pop;
  logic [27:0] obs_addr;

  function automatic logic [127:0] mkd(input logic [27:0] p);
    return {4'hD, p, 4'hE, p, 4'hA, p, 4'hD, p};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: I$ returns in order >=2 cycles after issue; pops are scored against exp_q.
  task automatic cyc();
    bit sent;
    if (rsp_en && icq_pc.size() != 0 && icq_t[0] + 2 <= cyc_n) begin
      ic2f_rsp_valid = 1'b1;
      ic2f_rsp_data  = mkd(icq_pc[0]);
    end else begin
      ic2f_rsp_valid = 1'b0;
      ic2f_rsp_data  = '0;
    end
    sent = ic2f_rsp_valid;
    #1;
    obs_reqv    = f2ic_req_valid;
    obs_readyin = ft2f_readyin;
    obs_rdy     = f2d_readyout;
    obs_addr    = f2ic_req_addr;
    obs_issue   = f2ic_req_valid & f2ic_req_ready;
    obs_pop     = f2d_readyout & f2d_readyin;
    if (obs_pop) begin
      chk("pop_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        chk("pop_packet", f2d_out_packet, mkd(exp_q[0]));
        chk("pop_virtpc", 128'(f2d_out_virtpc), 128'(exp_q[0]));
        void'(exp_q.pop_front());
        if (n_pop == 0) first_pop_t = cyc_n;
        last_pop_t = cyc_n;
        n_pop++;
      end
    end
    @(posedge clk); #1;
    if (sent) begin void'(icq_pc.pop_front()); void'(icq_t.pop_front()); end
    if (obs_issue) begin
      icq_pc.push_back(ft2f_in_virtpc);
      icq_t.push_back(cyc_n);
      exp_q.push_back(ft2f_in_virtpc);
      n_iss++;
    end
    if (pipe_flush) exp_q.delete();
    cyc_n++;
  endtask

  task automatic drain(input string tag);
    ft2f_readyout = 1'b0; f2d_readyin = 1'b1; rsp_en = 1'b1;
    for (int i = 0; i < 24 && (exp_q.size() != 0 || icq_pc.size() != 0); i++) cyc();
    chk({tag, "_drained"}, 128'(exp_q.size()), 128'd0);
    cyc();
    chk({tag, "_idle"}, 128'(obs_rdy), 128'd0);
  endtask

  task automatic issue_n(input int n);
    ft2f_readyout = 1'b1;
    n_iss = 0;
    for (int i = 0; i < n; i++) begin
      ft2f_in_virtpc = pc;
      cyc();
      if (obs_issue) pc++;
    end
    ft2f_readyout = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ft2f_readyout = 1'b1; f2ic_req_ready = 1'b1; f2d_readyin = 1'b1;
    ft2f_in_physpage = 20'hABCDE; ft2f_in_virtpc = 28'h1234567; pipe_flush = 1'b0;
    ic2f_rsp_valid = 1'b0; ic2f_rsp_data = '0; rsp_en = 1'b1;
    #12;
    chk("rst_req_valid", 128'(f2ic_req_valid), 0);
    chk("rst_readyin",   128'(ft2f_readyin), 0);
    chk("rst_readyout",  128'(f2d_readyout), 0);
    chk("rst_addr",      128'(f2ic_req_addr), 0);
    chk("rst_packet",    f2d_out_packet, 0);
    chk("rst_virtpc",    128'(f2d_out_virtpc), 0);
    ft2f_readyout = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Address composition, I$ not ready so nothing issues
    ft2f_readyout = 1'b1; f2ic_req_ready = 1'b0;
    cyc();
    chk("addr", 128'(obs_addr), 128'h0ABCDE67);
    chk("addr_req_valid", 128'(obs_reqv), 1);
    chk("addr_readyin_blocked", 128'(obs_readyin), 0);
    f2ic_req_ready = 1'b1; ft2f_readyout = 1'b0;

    // Stream 0x100..0x107
    pc = 28'h100; n_pop = 0; ft2f_readyout = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ft2f_readyout = (pc < 28'h108);
      ft2f_in_virtpc = pc;
      cyc();
      if (obs_issue) pc++;
    end
    chk("stream_count", 128'(n_pop), 8);
    chk("stream_no_gaps", 128'(last_pop_t - first_pop_t), 7);
    drain("stream");

    // Backpressure: exactly DEPTH issued, one pop frees one credit next cycle
    f2d_readyin = 1'b0; pc = 28'h300;
    issue_n(6);
    chk("bp_issued", 128'(n_iss), 4);
    chk("bp_readyin_low", 128'(obs_readyin), 0);
    ft2f_readyout = 1'b1; ft2f_in_virtpc = pc; f2d_readyin = 1'b1;
    cyc();
    chk("bp_pop", 128'(obs_pop), 1);
    chk("bp_pop_cycle_readyin", 128'(obs_readyin), 0);
    f2d_readyin = 1'b0;
    cyc();
    chk("bp_credit_back", 128'(obs_readyin), 1);
    chk("bp_issue_again", 128'(obs_issue), 1);
    pc++; ft2f_in_virtpc = pc;
    cyc();
    chk("bp_full_again", 128'(obs_readyin), 0);
    drain("bp");

    // Flush with 1 filled + 3 in flight -> 3 returns dropped
    f2d_readyin = 1'b0; pc = 28'h500;
    issue_n(1);
    cyc(); cyc();
    rsp_en = 1'b0;
    issue_n(3);
    chk("fl_issued", 128'(n_iss), 3);
    cyc();
    chk("fl_head_ready", 128'(obs_rdy), 1);
    ft2f_readyout = 1'b1; pipe_flush = 1'b1;
    cyc();
    chk("fl_readyout_low", 128'(obs_rdy), 0);
    chk("fl_no_req", 128'(obs_reqv), 0);
    pipe_flush = 1'b0; pc = 28'h200; ft2f_in_virtpc = pc;
    cyc();
    chk("fl_one_credit", 128'(obs_issue), 1);
    ft2f_readyout = 1'b0;
    cyc();
    chk("fl_credit_exhausted", 128'(obs_readyin), 0);
    n_pop = 0;
    drain("fl");
    chk("fl_only_new_pc", 128'(n_pop), 1);

    // Flush coincident with a response, 2 pending -> 1 drop
    rsp_en = 1'b0; f2d_readyin = 1'b0; pc = 28'h600;
    issue_n(2);
    cyc(); cyc();
    rsp_en = 1'b1; pipe_flush = 1'b1;
    cyc();
    pipe_flush = 1'b0; rsp_en = 1'b0; pc = 28'h610;
    issue_n(4);
    chk("fr_issued_three", 128'(n_iss), 3);
    chk("fr_readyin_low", 128'(obs_readyin), 0);
    n_pop = 0;
    drain("fr");
    chk("fr_new_pcs", 128'(n_pop), 3);

    // Response-to-decode latency
    f2d_readyin = 1'b1; rsp_en = 1'b1; pc = 28'h400;
    issue_n(1);
    cyc();
    cyc();
    chk("lat_rsp_cycle", 128'(obs_rdy), 128'(BYP));
    cyc();
    chk("lat_next_cycle", 128'(obs_rdy), 128'(!BYP));
    drain("lat");

    // Async reset mid-stream
    pc = 28'h700; ft2f_readyout = 1'b1;
    for (int i = 0; i < 3; i++) begin ft2f_in_virtpc = pc; cyc(); if (obs_issue) pc++; end
    ft2f_in_virtpc = pc;
    ic2f_rsp_valid = 1'b1; ic2f_rsp_data = mkd(28'h7FF);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_req_valid", 128'(f2ic_req_valid), 0);
    chk("ar_readyin",   128'(ft2f_readyin), 0);
    chk("ar_readyout",  128'(f2d_readyout), 0);
    chk("ar_addr",      128'(f2ic_req_addr), 0);
    chk("ar_packet",    f2d_out_packet, 0);
    ic2f_rsp_valid = 1'b0; ft2f_readyout = 1'b0;
    exp_q.delete(); icq_pc.delete(); icq_t.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    pc = 28'h7A0;
    issue_n(1);
    chk("ar_issue_after", 128'(n_iss), 1);
    drain("ar");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
